jstepper: RTL

JSTEPPER -- requirements
Module: jstepper

---
 rtl/jstepper_pkg.sv | 31 +++
 rtl/jphase.sv | 48 ++++
 rtl/jstepper.sv | 73 +++++++
 3 files changed

// File: rtl/jstepper_pkg.sv
// -----------------------------------------------------------------------------
// jstepper_pkg -- shared CPU sequencing constants.
//
// Holds the Gray-coded phase encodings (P0..P3) and the default number of
// instruction steps. Both the step sequencer and the control unit import this
// package, so the two always agree on what each phase value means.
// Also provides the jnand primitive and its inverter form, from which the
// phase counter's next-state and decode logic is built.
// -----------------------------------------------------------------------------
package jstepper_pkg;

    // Gray order: exactly one bit changes on every phase transition, so the
    // decoded enables never glitch between phases.
    typedef enum logic [1:0] {
        P0 = 2'b00,
        P1 = 2'b01,
        P2 = 2'b11,
        P3 = 2'b10
    } phase_t;

    localparam int NSTEPS_DEFAULT = 6;

    function automatic logic jnand(input logic a, input logic b);
        return ~(a & b);
    endfunction

    function automatic logic jinv(input logic a);
        return jnand(a, a);
    endfunction

endpackage

// File: rtl/jphase.sv
// -----------------------------------------------------------------------------
// jphase -- 4-phase Gray-coded phase counter.
//
// Ports:
//   wclk    in   system clock, all state changes on its rising edge
//   wreset  in   synchronous active-high reset, forces phase P3
//   whold   in   freezes the phase while high (reset takes priority)
//   phase   out  registered 2-bit Gray phase (P0->P1->P2->P3->P0)
//   wclke   out  enable phase, high in P0, P1, P2
//   wclks   out  set phase, high in P1 only
// -----------------------------------------------------------------------------
module jphase
    import jstepper_pkg::*;
(
    input  logic   wclk,
    input  logic   wreset,
    input  logic   whold,
    output phase_t phase,
    output logic   wclke,
    output logic   wclks
);

    logic nxt0;
    logic nxt1;

    // The Gray sequence 00,01,11,10 is a 2-bit twisted ring:
    // next[0] = ~phase[1], next[1] = phase[0].
    always_comb begin
        nxt0 = jinv(phase[1]);
        nxt1 = jinv(jinv(phase[0]));
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge wclk) begin
        if (wreset) begin
            phase <= P3;
        end else if (!whold) begin
            phase <= phase_t'({nxt1, nxt0});
        end
    end

    // wclke = NOT(P3) = NAND(phase[1], ~phase[0])
    // wclks = P1      = ~NAND(phase[0], ~phase[1])
    assign wclke = jnand(phase[1], jinv(phase[0]));
    assign wclks = jinv(jnand(phase[0], jinv(phase[1])));

endmodule

// File: rtl/jstepper.sv
// -----------------------------------------------------------------------------
// jstepper -- instruction step sequencer.
//
// Each step is four phases long (P0..P3); the one-hot step ring advances on
// the edge that leaves P3, wrapping from step NSTEPS back to step 1.
//
// Parameters:
//   NSTEPS  number of one-hot steps per instruction, 2..8
// Ports:
//   wclk    in   system clock
//   wreset  in   synchronous active-high reset (priority over whold)
//   whold   in   freezes phase and step while high
//   wclke   out  enable phase, high for 3 of the 4 phases
//   wclks   out  set phase, high in the middle phase only
//   bos     out  one-hot step vector, bos[0] is step 1
//   wwrap   out  high in the last phase of the last step
// -----------------------------------------------------------------------------
module jstepper
    import jstepper_pkg::*;
#(
    parameter int NSTEPS = NSTEPS_DEFAULT
) (
    input  logic              wclk,
    input  logic              wreset,
    input  logic              whold,
    output logic              wclke,
    output logic              wclks,
    output logic [NSTEPS-1:0] bos,
    output logic              wwrap
);

    phase_t phase;
    logic   fresh;
    logic   advance;

    jphase u_phase (
        .wclk   (wclk),
        .wreset (wreset),
        .whold  (whold),
        .phase  (phase),
        .wclke  (wclke),
        .wclks  (wclks)
    );

    // Reset parks the sequencer in P3 of step 1. The first P3->P0 edge after
    // reset must not advance the ring, otherwise step 1 would be skipped;
    // 'fresh' marks that single edge.
    always_ff @(posedge wclk) begin
        if (wreset) begin
            fresh <= 1'b1;
        end else if (!whold) begin
            fresh <= 1'b0;
        end
    end

    assign advance = !whold && (phase == P3) && !fresh;

    // Ring of flops, one hold/reset mux per bit. Reset loads exactly one set
    // bit and the rotate preserves it, so bos stays one-hot.
    always_ff @(posedge wclk) begin
        for (int k = 0; k < NSTEPS; k++) begin
            if (wreset) begin
                bos[k] <= (k == 0);
            end else if (advance) begin
                bos[k] <= bos[(k + NSTEPS - 1) % NSTEPS];
            end
        end
    end

    // Decoded straight from state; whold does not mask it.
    assign wwrap = bos[NSTEPS-1] && (phase == P3);

endmodule
